// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, ACK/NACK bus levels,
// byte/counter widths and the open-drain drive helper.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  // Open-drain: a 0 on the bus means pulling the pad low.
  function automatic logic drive_low(input logic bus_bit);
    return bus_bit == 1'b0;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer and bus event detector.
// Ports:
//   clk, areset_n  - system clock, async active-low reset
//   scl_di, sda_di - raw pad levels
//   scl_rise/fall  - single-clk SCL edge pulses (from synchronized samples)
//   start_det      - SDA fell while SCL stayed high
//   stop_det       - SDA rose while SCL stayed high
//   sda_s          - synchronized SDA level
module i2c_bus_sync (
  input  logic clk,
  input  logic areset_n,
  input  logic scl_di,
  input  logic sda_di,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] metastability stage, [1] synchronized sample, [2] history
  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_hi_stable;

  // Reset to the idle-high bus level so release of reset creates no events.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_di};
      sda_q <= {sda_q[1:0], sda_di};
    end
  end

  // SCL must be high in both samples: a simultaneous SCL/SDA change is data.
  assign scl_hi_stable = scl_q[1] & scl_q[2];
  assign scl_rise      = scl_q[1] & ~scl_q[2];
  assign scl_fall      = ~scl_q[1] & scl_q[2];
  assign start_det     = scl_hi_stable & ~sda_q[1] & sda_q[2];
  assign stop_det      = scl_hi_stable & sda_q[1] & ~sda_q[2];
  assign sda_s         = sda_q[1];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target responder feeding a synchronous register bank.
// Ports:
//   clk, areset_n        - system clock, async active-low reset
//   scl_di, sda_di       - pad input levels
//   sda_do               - 1 = pull SDA low
//   reg_addr             - register pointer (auto-increments, wraps)
//   reg_wdata, reg_we    - write byte and one-clk write strobe
//   reg_re, reg_rdata    - one-clk fetch strobe, data valid the clk after
//   busy                 - addressed, until STOP or repeated START
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'd16
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       scl_di,
  input  logic       sda_di,
  output logic       sda_do,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .areset_n  (areset_n),
    .scl_di    (scl_di),
    .sda_di    (sda_di),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_state_e          state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [BYTE_W-1:0]   reg_addr_q, reg_addr_d;
  logic [BYTE_W-1:0]   reg_wdata_q, reg_wdata_d;
  logic                rw_q, rw_d;
  logic                mack_q, mack_d;
  logic                ld_q, ld_d;
  logic                sda_do_q, sda_do_d;
  logic                reg_we_q, reg_we_d;
  logic                reg_re_q, reg_re_d;
  logic                busy_q, busy_d;
  logic                byte_done;
  logic                addr_match;

  assign byte_done  = scl_fall && (bit_cnt_q == CNT_W'(BYTE_W));
  // General call (address 0) is never answered.
  assign addr_match = (shift_q[7:1] == SLAVE_ADDR) && (SLAVE_ADDR != 7'd0);

  // State and datapath registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      rw_q        <= 1'b0;
      mack_q      <= I2C_NACK;
      ld_q        <= 1'b0;
      sda_do_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      rw_q        <= rw_d;
      mack_q      <= mack_d;
      ld_q        <= ld_d;
      sda_do_q    <= sda_do_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and output logic; START/STOP override everything at the end.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    rw_d        = rw_q;
    mack_d      = mack_q;
    sda_do_d    = sda_do_q;
    busy_d      = busy_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    // Read data arrives the clk after the fetch strobe.
    ld_d        = reg_re_q;

    // Post-increment the pointer once the write strobe has been seen.
    if (reg_we_q) begin
      reg_addr_d = reg_addr_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: ;
      ST_ADDR, ST_PTR, ST_WDATA: begin
        if (scl_rise) begin
          shift_d   = {shift_q[6:0], sda_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else if (byte_done) begin
          bit_cnt_d = '0;
          case (state_q)
            ST_ADDR: begin
              rw_d = shift_q[0];
              if (addr_match) begin
                state_d  = ST_ADDR_ACK;
                sda_do_d = drive_low(I2C_ACK);
                busy_d   = 1'b1;
              end else begin
                state_d  = ST_IGNORE;
                sda_do_d = 1'b0;
              end
            end
            ST_PTR: begin
              reg_addr_d = shift_q;
              state_d    = ST_PTR_ACK;
              sda_do_d   = drive_low(I2C_ACK);
            end
            default: begin
              reg_wdata_d = shift_q;
              state_d     = ST_WDATA_ACK;
              sda_do_d    = drive_low(I2C_ACK);
            end
          endcase
        end
      end
      ST_ADDR_ACK: begin
        if (scl_fall) begin
          sda_do_d = 1'b0;
          if (rw_q) begin
            reg_re_d = 1'b1;
            state_d  = ST_RDATA;
          end else begin
            state_d  = ST_PTR;
          end
        end
      end
      ST_PTR_ACK: begin
        if (scl_fall) begin
          sda_do_d = 1'b0;
          state_d  = ST_WDATA;
        end
      end
      ST_WDATA_ACK: begin
        if (scl_fall) begin
          sda_do_d = 1'b0;
          reg_we_d = 1'b1;
          state_d  = ST_WDATA;
        end
      end
      ST_RDATA: begin
        if (ld_q) begin
          // Present the MSB as soon as the fetched byte is latched.
          shift_d  = reg_rdata;
          sda_do_d = drive_low(reg_rdata[7]);
        end else if (scl_rise) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else if (byte_done) begin
          bit_cnt_d = '0;
          sda_do_d  = 1'b0;
          state_d   = ST_RDATA_ACK;
        end else if (scl_fall && (bit_cnt_q != '0)) begin
          shift_d  = {shift_q[6:0], 1'b0};
          sda_do_d = drive_low(shift_q[6]);
        end
      end
      ST_RDATA_ACK: begin
        if (scl_rise) begin
          mack_d = sda_s;
        end else if (scl_fall) begin
          if (mack_q == I2C_ACK) begin
            reg_addr_d = reg_addr_q + 8'd1;
            reg_re_d   = 1'b1;
            state_d    = ST_RDATA;
          end else begin
            state_d    = ST_IGNORE;
          end
        end
      end
      ST_IGNORE: sda_do_d = 1'b0;
      default:   state_d  = ST_IDLE;
    endcase

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      sda_do_d  = 1'b0;
      busy_d    = 1'b0;
      reg_we_d  = 1'b0;
      reg_re_d  = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      sda_do_d  = 1'b0;
      busy_d    = 1'b0;
      reg_we_d  = 1'b0;
      reg_re_d  = 1'b0;
    end
  end

  assign sda_do    = sda_do_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = busy_q;

endmodule
